// File: rtl/fu_ctrl_pkg.sv
// Shared types and constants for the FU elastic controller.
`timescale 1ns/1ps
package fu_ctrl_pkg;

   // FU output-select encodings; 2'd3 is treated like OUT_ALU.
   typedef enum logic [1:0] {
      OUT_ALU = 2'd0,
      OUT_CMP = 2'd1,
      OUT_MUX = 2'd2
   } out_sel_e;

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } ctrl_state_e;

   // Join channel indices.
   localparam int unsigned NUM_CH = 3;
   localparam int unsigned CH_1   = 0;
   localparam int unsigned CH_2   = 1;
   localparam int unsigned CH_C   = 2;

   function automatic logic sel_is_mux(input logic [1:0] sel);
      return sel == OUT_MUX;
   endfunction

endpackage

// File: rtl/fu_elastic_ctrl_if.sv
// Handshake bundle between the PE channels, the FU and the controller.
`timescale 1ns/1ps
interface fu_elastic_ctrl_if;
   logic valid_1;
   logic ready_1;
   logic valid_2;
   logic ready_2;
   logic cvalid;
   logic cready;
   logic valid;
   logic ready;
   logic fu_en;
   logic fu_feedback;
   logic busy;

   // Environment side: drives input valids and downstream ready.
   modport master (
      output valid_1, valid_2, cvalid, ready,
      input  ready_1, ready_2, cready, valid, fu_en, fu_feedback, busy
   );

   // Controller side.
   modport slave (
      input  valid_1, valid_2, cvalid, ready,
      output ready_1, ready_2, cready, valid, fu_en, fu_feedback, busy
   );
endinterface

// File: rtl/fu_join.sv
// N-input valid join: fires when every needed input is valid and the
// enable holds; consumes all needed inputs together on the fire cycle.
`timescale 1ns/1ps
module fu_join #(
   parameter int unsigned NUM_IN = 3
) (
   input  logic              enable_i,
   input  logic [NUM_IN-1:0] valid_i,
   input  logic [NUM_IN-1:0] need_i,
   output logic              fire_o,
   output logic [NUM_IN-1:0] ready_o
);

   // Unneeded inputs count as satisfied; readies only on needed inputs.
   always_comb begin
      fire_o  = enable_i & (&(valid_i | ~need_i));
      ready_o = fire_o ? need_i : '0;
   end

endmodule

// File: rtl/fu_elastic_ctrl.sv
// Elastic valid/ready controller for one CGRA PE data-FU: joins din_1,
// din_2 and cin, enables the FU register, counts accumulation iterations
// and emits one output token per completed result.
`timescale 1ns/1ps
module fu_elastic_ctrl
   import fu_ctrl_pkg::*;
#(
   parameter int unsigned ITER_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic                  feedback_i,
   input  logic [1:0]            out_sel_i,
   input  logic [ITER_WIDTH-1:0] iterations_i,
   fu_elastic_ctrl_if.slave      hs
);

   ctrl_state_e           state_q, state_d;
   logic [ITER_WIDTH-1:0] count_q, count_d;
   logic                  valid_q, valid_d;

   logic [ITER_WIDTH-1:0] last_idx;
   logic                  sel_mux;
   logic                  cnt_zero;
   logic                  last;
   logic                  join_en;
   logic                  fire;
   logic [NUM_CH-1:0]     ch_valid;
   logic [NUM_CH-1:0]     ch_need;
   logic [NUM_CH-1:0]     ch_ready;

   // Channel needs, last-iteration detect and the join enable.
   always_comb begin
      sel_mux  = sel_is_mux(out_sel_i);
      cnt_zero = (count_q == '0);
      // iterations_i == 0 behaves as a single iteration.
      last_idx = (iterations_i == '0) ? '0 : iterations_i - ITER_WIDTH'(1);
      last     = (count_q == last_idx);

      ch_valid       = '0;
      ch_valid[CH_1] = hs.valid_1;
      ch_valid[CH_2] = hs.valid_2;
      ch_valid[CH_C] = hs.cvalid;

      // In accumulate mode din_2 only seeds the first iteration.
      ch_need       = '0;
      ch_need[CH_1] = 1'b1;
      ch_need[CH_2] = sel_mux | ~feedback_i | cnt_zero;
      ch_need[CH_C] = sel_mux;

      // Blocking on a held token keeps dout_o stable until it is taken.
      join_en = (state_q == S_RUN) & en_i & ~clr_i & (~valid_q | hs.ready);
   end

   fu_join #(
      .NUM_IN (NUM_CH)
   ) u_join (
      .enable_i (join_en),
      .valid_i  (ch_valid),
      .need_i   (ch_need),
      .fire_o   (fire),
      .ready_o  (ch_ready)
   );

   // Next state for the FSM, iteration counter and output-valid flag.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      valid_d = valid_q;
      if (clr_i) begin
         state_d = S_LOAD;
         count_d = '0;
         valid_d = 1'b0;
      end else begin
         // LOAD lasts exactly one cycle: the FU initial-data load.
         if (state_q == S_LOAD) begin
            state_d = S_RUN;
         end
         if (fire) begin
            count_d = last ? '0 : count_q + ITER_WIDTH'(1);
         end
         // A new token wins over a same-cycle drain: back-to-back results.
         if (fire && last) begin
            valid_d = 1'b1;
         end else if (hs.ready) begin
            valid_d = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_LOAD;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign hs.ready_1     = ch_ready[CH_1];
   assign hs.ready_2     = ch_ready[CH_2];
   assign hs.cready      = ch_ready[CH_C];
   assign hs.fu_en       = fire;
   assign hs.valid       = valid_q;
   assign hs.busy        = ~cnt_zero;
   assign hs.fu_feedback = feedback_i & ~cnt_zero & ~sel_mux;

endmodule

// File: tb/tb_fu_elastic_ctrl.sv
// Self-checking bench for fu_elastic_ctrl: behavioural model plus
// directed scenarios with hand-computed expectations, then random traffic.
`timescale 1ns/1ps
module tb_fu_elastic_ctrl;

   localparam int unsigned IW = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clr_i = 1'b0;
   logic          en_i = 1'b0;
   logic          feedback_i = 1'b0;
   logic [1:0]    out_sel_i = 2'd0;
   logic [IW-1:0] iterations_i = 16'd1;

   fu_elastic_ctrl_if u_if ();

   fu_elastic_ctrl #(
      .ITER_WIDTH (IW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clr_i        (clr_i),
      .en_i         (en_i),
      .feedback_i   (feedback_i),
      .out_sel_i    (out_sel_i),
      .iterations_i (iterations_i),
      .hs           (u_if)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_cnt   = 0;   // fires completed in the current accumulation
   bit m_valid = 0;   // a result token is pending downstream
   bit m_run   = 0;   // initial-data load cycle is over

   function automatic int n_of();
      return (iterations_i == 0) ? 1 : int'(iterations_i);
   endfunction

   function automatic bit m_mux();
      return out_sel_i == 2'd2;
   endfunction

   function automatic bit m_need2();
      return m_mux() || !feedback_i || (m_cnt == 0);
   endfunction

   function automatic bit m_fire();
      return m_run && en_i && !clr_i && u_if.valid_1 && (u_if.valid_2 || !m_need2()) &&
             (u_if.cvalid || !m_mux()) && (!m_valid || u_if.ready);
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_cnt   <= 0;
         m_valid <= 0;
         m_run   <= 0;
      end else if (clr_i) begin
         m_cnt   <= 0;
         m_valid <= 0;
         m_run   <= 0;
      end else if (m_fire() && (m_cnt == n_of() - 1)) begin
         m_cnt   <= 0;
         m_valid <= 1;
         m_run   <= 1;
      end else begin
         if (m_fire()) m_cnt <= m_cnt + 1;
         if (u_if.ready) m_valid <= 0;
         m_run <= 1;
      end
   end

   // Compare every cycle, mid-way between the stimulus edge and the clock edge.
   always @(negedge clk_i) begin
      #3;
      chk("fu_en", u_if.fu_en, m_fire());
      chk("ready_1", u_if.ready_1, m_fire());
      chk("ready_2", u_if.ready_2, m_fire() && m_need2());
      chk("cready", u_if.cready, m_fire() && m_mux());
      chk("valid_o", u_if.valid, m_valid);
      chk("busy", u_if.busy, m_cnt != 0);
      chk("fu_feedback", u_if.fu_feedback, feedback_i && (m_cnt != 0) && !m_mux());
   end

   // ---------------- stimulus helpers ----------------
   bit v2_at_zero = 0;   // din_2 valid only while the accumulation count is 0

   task automatic drv(input bit v1, input bit v2, input bit cv, input bit rdy, input bit en,
                      input bit clr);
      @(negedge clk_i);
      u_if.valid_1 = v1;
      u_if.valid_2 = v2_at_zero ? (m_cnt == 0) : v2;
      u_if.cvalid  = cv;
      u_if.ready   = rdy;
      en_i         = en;
      clr_i        = clr;
      #3;
   endtask

   // Clear cycle carrying a new configuration; the following cycle is LOAD.
   task automatic cfg(input bit fb, input logic [1:0] sel, input logic [IW-1:0] it);
      @(negedge clk_i);
      feedback_i   = fb;
      out_sel_i    = sel;
      iterations_i = it;
      u_if.valid_1 = 0;
      u_if.valid_2 = 0;
      u_if.cvalid  = 0;
      u_if.ready   = 1;
      en_i         = 1;
      clr_i        = 1;
      #3;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fires;
      int r2;
      int vcnt;
      logic [3:0] fbpat;
      int its [6];

      u_if.valid_1 = 0;
      u_if.valid_2 = 0;
      u_if.cvalid  = 0;
      u_if.ready   = 0;

      // Reset: everything low.
      drv(1, 1, 1, 1, 1, 0);
      chk("rst_fu_en", u_if.fu_en, 0);
      chk("rst_readies", {u_if.ready_1, u_if.ready_2, u_if.cready}, 3'b000);
      chk("rst_valid_busy_fb", {u_if.valid, u_if.busy, u_if.fu_feedback}, 3'b000);
      @(posedge clk_i);
      #1 rst_ni = 1;

      // N=1, feedback off: LOAD cycle, then fire every cycle, valid_o from cycle 2.
      drv(1, 1, 1, 1, 1, 0);
      chk("t1_c0_fu_en", u_if.fu_en, 0);
      drv(1, 1, 1, 1, 1, 0);
      chk("t1_c1_fu_en", u_if.fu_en, 1);
      chk("t1_c1_valid", u_if.valid, 0);
      drv(1, 1, 1, 1, 1, 0);
      chk("t1_c2_fu_en", u_if.fu_en, 1);
      chk("t1_c2_valid", u_if.valid, 1);

      // Accumulate N=4 with din_2 only valid at count 0.
      cfg(1, 2'd0, 16'd4);
      drv(0, 0, 0, 1, 1, 0);
      v2_at_zero = 1;
      fires = 0; r2 = 0; vcnt = 0; fbpat = '0;
      for (int c = 0; c < 60 && fires < 16; c++) begin
         drv(1, 0, 0, 1, 1, 0);
         if (u_if.fu_en) begin
            if (fires < 4) fbpat[fires] = u_if.fu_feedback;
            fires++;
         end
         if (u_if.ready_2) r2++;
         if (u_if.valid) vcnt++;
      end
      v2_at_zero = 0;
      for (int c = 0; c < 2; c++) begin
         drv(0, 0, 0, 1, 1, 0);
         if (u_if.valid) vcnt++;
      end
      chk("t2_fires", fires, 16);
      chk("t2_ready2_pulses", r2, 4);
      chk("t2_feedback_pattern", fbpat, 4'b1110);
      chk("t2_tokens", vcnt, 4);

      // MUX with cin arriving 3 cycles late.
      cfg(0, 2'd2, 16'd1);
      drv(0, 0, 0, 1, 1, 0);
      for (int c = 0; c < 3; c++) begin
         drv(1, 1, 0, 1, 1, 0);
         chk("t3_wait", {u_if.fu_en, u_if.ready_1, u_if.ready_2, u_if.cready}, 4'b0000);
      end
      drv(1, 1, 1, 1, 1, 0);
      chk("t3_readies", {u_if.ready_1, u_if.ready_2, u_if.cready}, 3'b111);
      chk("t3_fire", u_if.fu_en, 1);

      // Held token with ready_i low: no fire for 5 cycles, then fire.
      for (int c = 0; c < 5; c++) begin
         drv(1, 1, 1, 0, 1, 0);
         chk("t4_blocked", {u_if.fu_en, u_if.valid}, 2'b01);
      end
      drv(1, 1, 1, 1, 1, 0);
      chk("t4_release", u_if.fu_en, 1);

      // iterations_i = 0 behaves as N = 1.
      cfg(0, 2'd0, 16'd0);
      drv(0, 0, 0, 1, 1, 0);
      drv(1, 1, 0, 1, 1, 0);
      chk("t5_n0_fire", {u_if.fu_en, u_if.busy}, 2'b10);
      drv(0, 0, 0, 1, 1, 0);
      chk("t5_n0_token", {u_if.valid, u_if.busy}, 2'b10);

      // clr_i at count 2.
      cfg(0, 2'd0, 16'd5);
      drv(0, 0, 0, 1, 1, 0);
      drv(1, 1, 0, 1, 1, 0);
      drv(1, 1, 0, 1, 1, 0);
      drv(0, 0, 0, 1, 1, 0);
      chk("t5_count2_busy", u_if.busy, 1);
      drv(1, 1, 0, 1, 1, 1);
      chk("t5_clr_nofire", u_if.fu_en, 0);
      drv(1, 1, 0, 1, 1, 0);
      chk("t5_load", {u_if.fu_en, u_if.busy, u_if.valid}, 3'b000);
      drv(1, 1, 0, 1, 1, 0);
      chk("t5_run", u_if.fu_en, 1);

      // Async reset mid-accumulation (count 3 of 8).
      cfg(0, 2'd0, 16'd8);
      drv(0, 0, 0, 1, 1, 0);
      for (int c = 0; c < 3; c++) drv(1, 1, 0, 1, 1, 0);
      drv(1, 1, 0, 1, 1, 0);
      chk("t6_before", {u_if.fu_en, u_if.busy}, 2'b11);
      rst_ni = 0;
      #1;
      chk("t6_async", {u_if.fu_en, u_if.busy, u_if.valid, u_if.ready_1}, 4'b0000);
      @(posedge clk_i);
      #1 rst_ni = 1;
      drv(1, 1, 0, 1, 1, 0);
      chk("t6_load", u_if.fu_en, 0);
      drv(1, 1, 0, 1, 1, 0);
      chk("t6_run", u_if.fu_en, 1);

      // Random traffic against the model.
      its = '{0, 1, 2, 3, 5, 7};
      for (int k = 0; k < 10; k++) begin
         cfg(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             16'(its[$urandom_range(0, 5)]));
         for (int c = 0; c < 200; c++) begin
            drv(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                ($urandom % 3) != 0, ($urandom % 8) != 0, ($urandom % 50) == 0);
         end
      end

      drv(0, 0, 0, 1, 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
